// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial-MAC FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_tapline.sv
// DW x TAPS sample delay line: shifts on en, newest sample at index 0, muxed read by index.
module fir_tapline
  import fir_pkg::*;
#(
  parameter int DW   = 4,
  parameter int TAPS = 4,
  parameter int AW   = fir_clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] d [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) d[k] <= '0;
    end else if (en) begin
      d[0] <= din;
      for (int k = 1; k < TAPS; k++) d[k] <= d[k-1];
    end
  end

  // Compare-based mux so a non-power-of-two TAPS never indexes past the array.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (rd_idx == AW'(k)) rd_data = d[k];
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// N-tap FIR with programmable coefficients, one multiply-accumulate per cycle.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int DW   = 4,
  parameter int CW   = 4,
  parameter int TAPS = 4,
  parameter int AW   = fir_clog2(TAPS),
  parameter int OW   = DW + CW + fir_clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_we,
  output logic          coef_ready,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output fir_state_e    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid must not depend on ready, and the source holds data stable until the transfer.
  fir_state_e        state;
  logic [CW-1:0]     coef [TAPS];
  logic [AW-1:0]     idx;
  logic [OW-1:0]     acc;
  logic [DW-1:0]     tap;
  logic [CW-1:0]     c_sel;
  logic [CW+DW-1:0]  prod;
  logic [OW-1:0]     sum;
  logic              accept;
  logic              coef_wr;

  assign in_ready   = (state == IDLE);
  assign coef_ready = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign coef_wr    = coef_we && coef_ready && (int'(coef_addr) < TAPS);
  assign dbg_state  = state;

  fir_tapline #(.DW(DW), .TAPS(TAPS), .AW(AW)) u_tapline (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .din     (in_data),
    .rd_idx  (idx),
    .rd_data (tap)
  );

  always_comb begin
    c_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == AW'(k)) c_sel = coef[k];
    end
  end

  assign prod = (CW+DW)'(c_sel) * (CW+DW)'(tap);
  assign sum  = acc + OW'(prod);

  // A write landing on the same edge as a sample accept is seen by that sample's MAC pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= CW'(k + 1);
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_wr && coef_addr == AW'(k)) coef[k] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (idx == AW'(TAPS - 1)) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= sum;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: directed scenarios plus a random stream against a convolution model.
module tb_fir_serial_mac;
  import fir_pkg::*;

  localparam int DW = 4, CW = 4, TAPS = 4, AW = 2, OW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, coef_we, coef_ready, out_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;
  logic [OW-1:0] out_data;
  fir_state_e    state;

  logic          t3_in_valid, t3_in_ready, t3_coef_we, t3_coef_ready, t3_out_valid, t3_out_ready;
  logic [DW-1:0] t3_in_data;
  logic [1:0]    t3_coef_addr;
  logic [CW-1:0] t3_coef_data;
  logic [9:0]    t3_out_data;
  fir_state_e    t3_state;

  fir_serial_mac #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_ready(coef_ready), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .dbg_state(state)
  );

  fir_serial_mac #(.DW(4), .CW(4), .TAPS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(t3_in_valid), .in_ready(t3_in_ready), .in_data(t3_in_data),
    .coef_we(t3_coef_we), .coef_ready(t3_coef_ready), .coef_addr(t3_coef_addr),
    .coef_data(t3_coef_data), .out_valid(t3_out_valid), .out_ready(t3_out_ready),
    .out_data(t3_out_data), .dbg_state(t3_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model + scoreboard ----------------
  int m_coef [TAPS];
  int m_hist [TAPS];
  logic [OW-1:0] exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = (k + 1) % (1 << CW);
      m_hist[k] = 0;
    end
    exp_q.delete();
  endtask

  function automatic logic [OW-1:0] model_accept(input int x);
    int s;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_hist[k];
    return OW'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    out_ready = 1'b0;
    t3_in_valid = 1'b0; t3_in_data = '0; t3_coef_we = 1'b0; t3_coef_addr = '0;
    t3_coef_data = '0; t3_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Sends one sample, returns the result and the cycles from accept edge to out_valid.
  task automatic xfer(input int x, output logic [OW-1:0] got, output logic [OW-1:0] exp_v,
                      output int lat, output bit to);
    int t;
    t = 0;
    to = 1'b0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    in_valid = 1'b1;
    in_data  = DW'(x);
    @(posedge clk);
    exp_v = model_accept(x);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!out_valid || t >= 50) to = 1'b1;
    got = out_data;
  endtask

  task automatic write_coef(input int addr, input int data);
    int t;
    t = 0;
    while (!coef_ready && t < 50) begin @(negedge clk); t++; end
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = CW'(data);
    @(posedge clk);
    if (addr < TAPS) m_coef[addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (coef_ready !== 1'b1) begin n_err++; $display("FAIL reset_coef_ready: got %b want 1", coef_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_impulse();
    int samp [5] = '{1, 0, 0, 0, 0};
    logic [OW-1:0] want [5] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0};
    logic [OW-1:0] got, ev;
    int lat;
    bit to;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(samp[i], got, ev, lat, to);
      n_vec++; if (to || got !== want[i]) begin n_err++; $display("FAIL impulse[%0d]: got %0d want %0d", i, got, want[i]); end
      n_vec++; if (lat != TAPS) begin n_err++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, TAPS); end
    end
  endtask

  task automatic test_max();
    logic [OW-1:0] want [5] = '{10'd15, 10'd45, 10'd90, 10'd150, 10'd150};
    logic [OW-1:0] got, ev;
    int lat;
    bit to;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(15, got, ev, lat, to);
      n_vec++; if (to || got !== want[i]) begin n_err++; $display("FAIL max[%0d]: got %0d want %0d", i, got, want[i]); end
    end
    for (int k = 0; k < TAPS; k++) write_coef(k, 15);
    for (int i = 0; i < 4; i++) begin
      xfer(15, got, ev, lat, to);
      n_vec++; if (to || got !== 10'd900) begin n_err++; $display("FAIL max_c15[%0d]: got %0d want 900", i, got); end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] got, ev;
    int lat;
    bit to;
    do_reset();
    out_ready = 1'b0;
    xfer(7, got, ev, lat, to);
    n_vec++; if (to || got !== 10'd7) begin n_err++; $display("FAIL bp_first: got %0d want 7", got); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 10'd7 || in_ready !== 1'b0 || state !== DONE) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d in_ready=%b state=%0d want 1/7/0/%0d",
                 i, out_valid, out_data, in_ready, state, DONE);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || state !== IDLE || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid=%b state=%0d in_ready=%b want 0/%0d/1", out_valid, state, in_ready, IDLE);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_coef_write();
    logic [OW-1:0] got, ev;
    logic [OW-1:0] want3 [3] = '{10'd1, 10'd2, 10'd3};
    int lat, t;
    bit to;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = '0;
    @(posedge clk);
    ev = model_accept(0);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 4'd5;
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (coef_ready !== 1'b0) begin n_err++; $display("FAIL coef_busy[%0d]: got %b want 0", i, coef_ready); end
      @(posedge clk); @(negedge clk);
    end
    coef_we = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); t++; @(negedge clk); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 10'd0) begin n_err++; $display("FAIL coef_zero: valid=%b data=%0d want 1/0", out_valid, out_data); end
    out_ready = 1'b1;
    xfer(1, got, ev, lat, to);
    n_vec++; if (to || got !== 10'd1) begin n_err++; $display("FAIL coef_ignored: got %0d want 1", got); end

    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'd2;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 4'd5;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin @(posedge clk); t++; @(negedge clk); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 10'd10) begin n_err++; $display("FAIL coef_same_edge: valid=%b data=%0d want 1/10", out_valid, out_data); end
    @(posedge clk); @(negedge clk);

    // Three-tap instance: address 3 is out of range and must leave coefficients 1,2,3 intact.
    t3_out_ready = 1'b1;
    n_vec++; if (t3_coef_ready !== 1'b1) begin n_err++; $display("FAIL t3_coef_ready: got %b want 1", t3_coef_ready); end
    t3_coef_we = 1'b1; t3_coef_addr = 2'd3; t3_coef_data = 4'd15;
    @(posedge clk); @(negedge clk);
    t3_coef_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t3_in_valid = 1'b1; t3_in_data = (i == 0) ? 4'd1 : 4'd0;
      @(posedge clk); @(negedge clk);
      t3_in_valid = 1'b0;
      t = 0;
      while (!t3_out_valid && t < 20) begin @(posedge clk); t++; @(negedge clk); end
      n_vec++;
      if (t3_out_valid !== 1'b1 || t3_out_data !== want3[i]) begin
        n_err++; $display("FAIL t3_impulse[%0d]: valid=%b data=%0d want 1/%0d", i, t3_out_valid, t3_out_data, want3[i]);
      end
      @(posedge clk); @(negedge clk);
    end
    t3_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    logic [OW-1:0] want [4] = '{10'd1, 10'd2, 10'd3, 10'd4};
    logic [OW-1:0] got, ev;
    int lat;
    bit to, seen;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'd9;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL abort_no_valid: got out_valid=1 want 0"); end
    n_vec++; if (state !== IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", state, IDLE); end
    for (int i = 0; i < 4; i++) begin
      xfer((i == 0) ? 1 : 0, got, ev, lat, to);
      n_vec++; if (to || got !== want[i]) begin n_err++; $display("FAIL abort_impulse[%0d]: got %0d want %0d", i, got, want[i]); end
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 40;
    int rcvd;
    do_reset();
    rcvd = 0;
    fork
      begin : driver
        for (int i = 0; i < N; i++) begin
          int x, a, cd, t;
          bit do_c, accepted;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          x = $urandom_range(0, 15);
          do_c = ($urandom_range(0, 3) == 0);
          a = $urandom_range(0, TAPS - 1);
          cd = $urandom_range(0, 15);
          in_valid = 1'b1; in_data = DW'(x);
          if (do_c) begin coef_we = 1'b1; coef_addr = AW'(a); coef_data = CW'(cd); end
          t = 0; accepted = 1'b0;
          while (!accepted && t < 100) begin
            accepted = in_ready;
            @(posedge clk); @(negedge clk);
            t++;
          end
          in_valid = 1'b0; coef_we = 1'b0;
          n_vec++;
          if (!accepted) begin
            n_err++; $display("FAIL rand_accept[%0d]: timeout waiting for in_ready", i);
            break;
          end
          if (do_c) m_coef[a] = cd;
          exp_q.push_back(model_accept(x));
        end
      end
      begin : monitor
        int cyc;
        bit rdy;
        logic [OW-1:0] e;
        cyc = 0;
        while (rcvd < N && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          rdy = 1'($urandom_range(0, 1));
          out_ready = rdy;
          if (out_valid && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL rand_extra: unexpected output %0d", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin n_err++; $display("FAIL rand_out[%0d]: got %0d want %0d", rcvd, out_data, e); end
            end
            rcvd++;
          end
        end
      end
    join
    out_ready = 1'b0;
    n_vec++;
    if (rcvd != N || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_count: got %0d outputs (%0d pending) want %0d", rcvd, exp_q.size(), N);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b0;
    t3_in_valid = 1'b0; t3_in_data = '0; t3_coef_we = 1'b0; t3_coef_addr = '0;
    t3_coef_data = '0; t3_out_ready = 1'b0;
    test_reset();
    test_impulse();
    test_max();
    test_backpressure();
    test_coef_write();
    test_reset_mid_mac();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
